shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 SHALL have no parameters; datapath width fixed at 32.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 in_valid  input  1  request present.
REQ-005 in_ready  output  1  sequencer can accept a request.
REQ-006 operand  input  32  value to shift.
REQ-007 shift_type  input  2  00 LSL, 01 LSR, 10 ASR, 11 ROR.
REQ-008 amt  input  8  shift amount; immediate form uses amt[4:0] only.
REQ-009 imm_form  input  1  1 = immediate-specified shift, 0 = register-specified.
REQ-010 carry_in  input  1  current C flag.
REQ-011 out_valid  output  1  result and carry_out valid.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 result  output  32  shifted operand.
REQ-014 carry_out  output  1  shifter carry.

Function
REQ-015 SHALL implement FSM IDLE -> SHIFT -> DONE -> IDLE; in_ready = 1 only in IDLE.
REQ-016 Accept on edge with in_valid & in_ready: operand, shift_type, amt, imm_form and carry_in captured into registers; state -> SHIFT.
REQ-017 SHIFT lasts exactly one cycle; at its closing edge result/carry_out registered, state -> DONE, out_valid = 1 (result visible two cycles after accept edge).
REQ-018 DONE holds result, carry_out and out_valid stable until edge with out_ready = 1; state -> IDLE, out_valid -> 0; no new accept in same cycle.
REQ-019 Input changes outside the accept edge SHALL not affect an in-flight operation.
REQ-020 Effective amount n: immediate form n = amt[4:0]; register form n = amt[7:0] (0..255).
REQ-021 Any form, n = 0 except immediate LSR/ASR/ROR: result = operand, carry_out = carry_in.
REQ-022 LSL n 1..31: rotate left n, clear low n bits; carry = operand[32-n]. n = 32: 0, carry operand[0]. n > 32: 0, carry 0.
REQ-023 LSR n 1..31: rotate right n, clear top n bits; carry = operand[n-1]. Immediate #0 treated as n = 32. n = 32: 0, carry operand[31]. n > 32: 0, carry 0.
REQ-024 ASR n 1..31: rotate right n, fill top n bits with operand[31]; carry = operand[n-1]. Immediate #0 or n >= 32: all bits = operand[31], carry = operand[31].
REQ-025 ROR immediate #0 = RRX: result = {carry_in, operand[31:1]}, carry = operand[0].
REQ-026 ROR n > 0: rotate right n[4:0]; carry = result[31]; n[4:0] = 0 (32, 64, ...): result = operand, carry = operand[31].
REQ-027 All rotations SHALL pass through one shared rotate core; masking/fill and carry selection are done by the sequencer.

Reset
REQ-028 rst at an edge: state -> IDLE, out_valid = 0, result = 0, carry_out = 0, captured registers = 0; in_ready = 1 the cycle after.
REQ-029 rst in SHIFT or DONE SHALL discard the operation with no out_valid pulse; rst overrides a simultaneous accept.

Structure
REQ-030 Shared package shift_pkg SHALL hold shift_type encodings (LSL, LSR, ASR, ROR), FSM state encoding, and ROTATE_LEFT = 1 / ROTATE_RIGHT = 0 direction constants.
REQ-031 Exactly one sub-module instance: barrel_shifter (32-bit rotate core, dir_lr 1 = left), driven from captured registers.

Verification
REQ-032 Reset then operand 0x8000_0001, LSL imm 1, carry_in 0 -> result 0x0000_0002, carry_out 1, out_valid two cycles after accept.
REQ-033 LSR imm #0 on 0x8000_0000 -> result 0, carry 1; ASR reg n = 40 on 0x8000_0000 -> 0xFFFF_FFFF, carry 1.
REQ-034 ROR imm #0 (RRX), operand 0x0000_0003, carry_in 1 -> 0x8000_0001, carry 1; ROR reg n = 32 on 0x8000_0000 -> 0x8000_0000, carry 1.
REQ-035 out_ready held 0 for 5 cycles in DONE -> result/out_valid stable, in_ready 0; in_valid toggled meanwhile ignored.
REQ-036 rst asserted during SHIFT -> no out_valid, all outputs 0, next request LSL reg n = 0 on 0x1234_5678, carry_in 1 -> 0x1234_5678, carry 1.

Source files
------------

// File: rtl/shift_pkg.sv
// ============================================================================
//  Module      : shift_pkg
//  Description : Shared constants for the shift sequencer: shift-type
//                encodings, FSM state encoding and rotate directions.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package shift_pkg;

    // Shift-type encodings as presented on shift_type
    localparam logic [1:0] SHIFT_LSL = 2'b00;
    localparam logic [1:0] SHIFT_LSR = 2'b01;
    localparam logic [1:0] SHIFT_ASR = 2'b10;
    localparam logic [1:0] SHIFT_ROR = 2'b11;

    // Sequencer FSM state encoding
    localparam logic [1:0] ST_IDLE  = 2'b00;
    localparam logic [1:0] ST_SHIFT = 2'b01;
    localparam logic [1:0] ST_DONE  = 2'b10;

    // Rotate core direction select
    localparam logic ROTATE_LEFT  = 1'b1;
    localparam logic ROTATE_RIGHT = 1'b0;

    // Datapath width
    localparam int DATA_W = 32;

endpackage : shift_pkg

`default_nettype wire

// File: rtl/shift_sequencer_if.sv
// ============================================================================
//  Module      : shift_sequencer_if
//  Description : Request/response bundle of the shift sequencer. The master
//                side issues requests and consumes results; the slave side
//                is the sequencer itself.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface shift_sequencer_if;

    // Request channel
    logic        in_valid;
    logic        in_ready;
    logic [31:0] operand;
    logic [1:0]  shift_type;
    logic [7:0]  amt;
    logic        imm_form;
    logic        carry_in;

    // Response channel
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        carry_out;

    modport master (
        output in_valid, operand, shift_type, amt, imm_form, carry_in, out_ready,
        input  in_ready, out_valid, result, carry_out
    );

    modport slave (
        input  in_valid, operand, shift_type, amt, imm_form, carry_in, out_ready,
        output in_ready, out_valid, result, carry_out
    );

endinterface : shift_sequencer_if

`default_nettype wire

// File: rtl/barrel_shifter.sv
// ============================================================================
//  Module      : barrel_shifter
//  Description : 32-bit combinational rotate core, five log-stages.
//                i_dir_lr = 1 rotates left, 0 rotates right.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module barrel_shifter
    import shift_pkg::*;
(
    input  wire logic [31:0] i_data,
    input  wire logic [4:0]  i_amt,
    input  wire logic        i_dir_lr,
    output logic      [31:0] o_data
);

    logic [31:0] w_stg [0:5];

    assign w_stg[0] = i_data;

    // Stage k rotates by 2**k when amount bit k is set
    for (genvar gi = 0; gi < 5; gi++) begin : g_stage
        localparam int SH = 1 << gi;
        assign w_stg[gi+1] = !i_amt[gi] ? w_stg[gi] :
                             (i_dir_lr == ROTATE_LEFT) ?
                                 {w_stg[gi][31-SH:0], w_stg[gi][31:32-SH]} :
                                 {w_stg[gi][SH-1:0],  w_stg[gi][31:SH]};
    end

    assign o_data = w_stg[5];

endmodule : barrel_shifter

`default_nettype wire

// File: rtl/shift_sequencer.sv
// ============================================================================
//  Module      : shift_sequencer
//  Description : Three-state (IDLE/SHIFT/DONE) ARM-style shifter sequencer.
//                Captures one request, computes LSL/LSR/ASR/ROR/RRX through a
//                shared rotate core, then holds the result until consumed.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module shift_sequencer
    import shift_pkg::*;
(
    input  wire logic         clk,
    input  wire logic         rst,
    shift_sequencer_if.slave  bus
);

    // Captured request
    logic [1:0]  r_state;
    logic [31:0] r_operand;
    logic [1:0]  r_type;
    logic [7:0]  r_amt;
    logic        r_imm;
    logic        r_cin;

    // Held response
    logic [31:0] r_result;
    logic        r_carry;
    logic        r_out_valid;

    // Datapath
    logic [7:0]  w_n8;
    logic [4:0]  w_n5;
    logic        w_imm_zero;
    logic        w_dir;
    logic [31:0] w_rot;
    logic [31:0] w_lo_keep;
    logic [31:0] w_hi_keep;
    logic        w_sign;
    logic [31:0] w_res;
    logic        w_cout;

    // Immediate form only sees five amount bits; register form sees all eight
    assign w_n8       = r_imm ? {3'b000, r_amt[4:0]} : r_amt;
    assign w_n5       = w_n8[4:0];
    assign w_imm_zero = r_imm && (r_amt[4:0] == 5'd0);
    assign w_dir      = (r_type == SHIFT_LSL) ? ROTATE_LEFT : ROTATE_RIGHT;
    assign w_sign     = r_operand[31];

    // Masks that keep the bits surviving a left / right shift by n[4:0]
    assign w_lo_keep  = 32'hFFFF_FFFF << w_n5;
    assign w_hi_keep  = 32'hFFFF_FFFF >> w_n5;

    barrel_shifter u_rotate (
        .i_data   (r_operand),
        .i_amt    (w_n5),
        .i_dir_lr (w_dir),
        .o_data   (w_rot)
    );

    // Turn the rotated operand into the requested shift and pick the carry
    always_comb begin
        w_res  = r_operand;
        w_cout = r_cin;
        case (r_type)
            SHIFT_LSL: begin
                if (w_n8 == 8'd0) begin
                    w_res  = r_operand;
                    w_cout = r_cin;
                end else if (w_n8 < 8'd32) begin
                    w_res  = w_rot & w_lo_keep;
                    w_cout = w_rot[0];
                end else if (w_n8 == 8'd32) begin
                    w_res  = 32'd0;
                    w_cout = r_operand[0];
                end else begin
                    w_res  = 32'd0;
                    w_cout = 1'b0;
                end
            end
            SHIFT_LSR: begin
                if (w_imm_zero || (w_n8 == 8'd32)) begin
                    w_res  = 32'd0;
                    w_cout = r_operand[31];
                end else if (w_n8 == 8'd0) begin
                    w_res  = r_operand;
                    w_cout = r_cin;
                end else if (w_n8 < 8'd32) begin
                    w_res  = w_rot & w_hi_keep;
                    w_cout = w_rot[31];
                end else begin
                    w_res  = 32'd0;
                    w_cout = 1'b0;
                end
            end
            SHIFT_ASR: begin
                if (w_imm_zero || (w_n8 >= 8'd32)) begin
                    w_res  = {32{w_sign}};
                    w_cout = w_sign;
                end else if (w_n8 == 8'd0) begin
                    w_res  = r_operand;
                    w_cout = r_cin;
                end else begin
                    w_res  = (w_rot & w_hi_keep) | ({32{w_sign}} & ~w_hi_keep);
                    w_cout = w_rot[31];
                end
            end
            default: begin
                // ROR; immediate #0 is RRX through the carry flag
                if (w_imm_zero) begin
                    w_res  = {r_cin, r_operand[31:1]};
                    w_cout = r_operand[0];
                end else if (w_n8 == 8'd0) begin
                    w_res  = r_operand;
                    w_cout = r_cin;
                end else begin
                    w_res  = w_rot;
                    w_cout = w_rot[31];
                end
            end
        endcase
    end

    // Sequencer FSM: capture in IDLE, compute in SHIFT, hold in DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_operand   <= 32'd0;
            r_type      <= 2'b00;
            r_amt       <= 8'd0;
            r_imm       <= 1'b0;
            r_cin       <= 1'b0;
            r_result    <= 32'd0;
            r_carry     <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        r_operand <= bus.operand;
                        r_type    <= bus.shift_type;
                        r_amt     <= bus.amt;
                        r_imm     <= bus.imm_form;
                        r_cin     <= bus.carry_in;
                        r_state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    r_result    <= w_res;
                    r_carry     <= w_cout;
                    r_out_valid <= 1'b1;
                    r_state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = (r_state == ST_IDLE);
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.carry_out = r_carry;

endmodule : shift_sequencer

`default_nettype wire
